// File: rtl/cat_cmd_parser.sv
// Byte-command parser for the cat LED board: single letters shoot or revive one cat,
// and '#' followed by two hex digits loads all eight cats at once.
module cat_cmd_parser #(
  parameter int          TIMEOUT_CYCLES = 4800000,
  parameter logic [7:0]  RESET_MASK     = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  output logic       rx_rd,
  output logic [7:0] cat_status,
  output logic       cmd_valid,
  output logic [7:0] err_count,
  output logic [7:0] last_byte
);

  typedef enum logic [1:0] {IDLE, HEX_HI, HEX_LO} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  idle_cnt;
  logic [3:0]     hi_nib;
  logic           pop;
  logic           timeout;
  logic           hex_ok;
  logic [3:0]     hex_val;
  logic [7:0]     off_upper, off_lower;
  logic           cmd_fire, err_inc, nib_load;
  logic [7:0]     status_nxt;

  // A byte is captured on the edge that raises rx_rd and decoded while rx_rd is high,
  // so rx_rd doubles as the "byte ready" strobe and enforces the one-cycle gap.
  assign pop     = !rx_empty && !rx_rd;
  assign timeout = (state != IDLE) && !rx_rd && !pop &&
                   (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign off_upper = last_byte - 8'h41;
  assign off_lower = last_byte - 8'h61;

  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (last_byte >= 8'h30 && last_byte <= 8'h39)      hex_val = last_byte[3:0];
    else if (last_byte >= 8'h41 && last_byte <= 8'h46) hex_val = last_byte[3:0] + 4'd9;
    else if (last_byte >= 8'h61 && last_byte <= 8'h66) hex_val = last_byte[3:0] + 4'd9;
    else                                               hex_ok  = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each combinational output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (rx_rd) begin
      case (state)
        IDLE:    if (last_byte == 8'h23) state_nxt = HEX_HI;
        HEX_HI:  state_nxt = hex_ok ? HEX_LO : IDLE;
        HEX_LO:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_fire   = 1'b0;
    err_inc    = timeout;
    nib_load   = 1'b0;
    status_nxt = cat_status;
    if (rx_rd) begin
      case (state)
        IDLE: begin
          if (last_byte >= 8'h41 && last_byte <= 8'h48) begin
            status_nxt[off_upper[2:0]] = 1'b0;
            cmd_fire = 1'b1;
          end else if (last_byte >= 8'h61 && last_byte <= 8'h68) begin
            status_nxt[off_lower[2:0]] = 1'b1;
            cmd_fire = 1'b1;
          end else if (last_byte != 8'h23 && last_byte != 8'h0A &&
                       last_byte != 8'h0D && last_byte != 8'h20) begin
            err_inc = 1'b1;
          end
        end
        HEX_HI: begin
          if (hex_ok) nib_load = 1'b1;
          else        err_inc  = 1'b1;
        end
        HEX_LO: begin
          if (hex_ok) begin
            status_nxt = {hi_nib, hex_val};
            cmd_fire   = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_rd      <= 1'b0;
      last_byte  <= 8'h00;
      cat_status <= RESET_MASK;
      cmd_valid  <= 1'b0;
      err_count  <= 8'h00;
      hi_nib     <= 4'h0;
      idle_cnt   <= '0;
    end else begin
      rx_rd      <= pop;
      if (pop) last_byte <= rx_data;
      cat_status <= status_nxt;
      cmd_valid  <= cmd_fire;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (nib_load) hi_nib <= hex_val;
      // Any byte activity restarts the inter-byte window; IDLE keeps it parked at zero.
      if (state == IDLE || pop || rx_rd || timeout) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cat_cmd_parser.sv
// Directed bench for cat_cmd_parser: a FWFT FIFO model feeds bytes, a vector table
// checks single-byte effects, and hand sequences cover gaps, timeouts and reset.
module tb_cat_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd;
  logic [7:0] cat_status;
  logic       cmd_valid;
  logic [7:0] err_count;
  logic [7:0] last_byte;

  cat_cmd_parser #(.TIMEOUT_CYCLES(16), .RESET_MASK(8'hFF)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
    .cat_status(cat_status), .cmd_valid(cmd_valid), .err_count(err_count),
    .last_byte(last_byte)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  int head = 0;
  int tail = 0;
  assign rx_empty = (head == tail);
  assign rx_data  = mem[head[9:0]];

  always @(posedge clk) if (rx_rd && head != tail) head <= head + 1;

  int cmd_cnt  = 0;
  int rd_viol  = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) if (cmd_valid === 1'b1) cmd_cnt++;
  always @(negedge clk) begin
    if (rx_rd && (prev_rd || rx_empty)) rd_viol++;
    prev_rd = rx_rd;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[tail[9:0]] = b;
    tail++;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (head != tail && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(head == tail), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] exp_status;
    logic [7:0] exp_err;
    int         exp_cmds;
  } vec_t;

  vec_t vecs [20];
  int   c0;

  initial begin
    vecs[0]  = '{8'h43, 8'hFB, 8'd0, 1};   // 'C' shoots cat 2
    vecs[1]  = '{8'h0A, 8'hFB, 8'd0, 0};
    vecs[2]  = '{8'h78, 8'hFB, 8'd1, 0};   // 'x' rejected
    vecs[3]  = '{8'h61, 8'hFB, 8'd1, 1};   // 'a' on live cat still pulses
    vecs[4]  = '{8'h41, 8'hFA, 8'd1, 1};
    vecs[5]  = '{8'h48, 8'h7A, 8'd1, 1};
    vecs[6]  = '{8'h63, 8'h7E, 8'd1, 1};
    vecs[7]  = '{8'h20, 8'h7E, 8'd1, 0};
    vecs[8]  = '{8'h23, 8'h7E, 8'd1, 0};
    vecs[9]  = '{8'h30, 8'h7E, 8'd1, 0};
    vecs[10] = '{8'h30, 8'h00, 8'd1, 1};   // "#00"
    vecs[11] = '{8'h68, 8'h80, 8'd1, 1};
    vecs[12] = '{8'h23, 8'h80, 8'd1, 0};
    vecs[13] = '{8'h66, 8'h80, 8'd1, 0};
    vecs[14] = '{8'h47, 8'h80, 8'd2, 0};   // 'G' is not hex in HEX_LO
    vecs[15] = '{8'h42, 8'h80, 8'd2, 1};
    vecs[16] = '{8'h23, 8'h80, 8'd2, 0};
    vecs[17] = '{8'h23, 8'h80, 8'd3, 0};   // '#' inside hex is an error
    vecs[18] = '{8'h62, 8'h82, 8'd3, 1};
    vecs[19] = '{8'h0D, 8'h82, 8'd3, 0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_status", cat_status, 8'hFF);
    check("rst_err", err_count, 8'h00);
    check("rst_last", last_byte, 8'h00);
    check("rst_rd", rx_rd, 1'b0);
    check("rst_cmd", cmd_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // First command with exact-cycle latency checks.
    push(vecs[0].b);
    @(posedge clk); #1;
    check("c_rd", rx_rd, 1'b1);
    check("c_status_pre", cat_status, 8'hFF);
    @(posedge clk); #1;
    check("c_status", cat_status, 8'hFB);
    check("c_cmd", cmd_valid, 1'b1);
    @(posedge clk); #1;
    check("c_cmd_one", cmd_valid, 1'b0);
    drain("c");

    for (int i = 1; i < 20; i++) begin
      c0 = cmd_cnt;
      push(vecs[i].b);
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_status", i), cat_status, vecs[i].exp_status);
      check($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
      check($sformatf("v%0d_cmds", i), cmd_cnt - c0, vecs[i].exp_cmds);
      check($sformatf("v%0d_last", i), last_byte, vecs[i].b);
    end

    c0 = cmd_cnt;
    push(8'h23); push(8'h35); push(8'h61);
    drain("hex5a");
    check("hex5a_status", cat_status, 8'h5A);
    check("hex5a_cmds", cmd_cnt - c0, 1);

    push(8'h23); push(8'h47);
    drain("hexg");
    check("hexg_err", err_count, 8'd4);
    check("hexg_status", cat_status, 8'h5A);
    push(8'h61);
    drain("hexg_a");
    check("hexg_a_status", cat_status, 8'h5B);

    c0 = cmd_cnt;
    push(8'h23); push(8'h33);
    drain("to");
    repeat (30) @(negedge clk);
    check("to_err", err_count, 8'd5);
    push(8'h37);
    drain("to7");
    check("to7_err", err_count, 8'd6);
    check("to7_status", cat_status, 8'h5B);
    check("to7_cmds", cmd_cnt - c0, 0);

    // Gaps shorter than the timeout, total longer: the counter restarts per byte.
    push(8'h23); drain("gap0"); repeat (8) @(negedge clk);
    push(8'h31); drain("gap1"); repeat (8) @(negedge clk);
    push(8'h32); drain("gap2");
    check("gap_status", cat_status, 8'h12);
    check("gap_err", err_count, 8'd6);

    for (int i = 0; i < 300; i++) push(8'h7A);
    drain("sat");
    check("sat_err", err_count, 8'hFF);

    c0 = cmd_cnt;
    push(8'h23);
    drain("rst_mid");
    reset = 1'b1;
    #2;
    check("mid_status", cat_status, 8'hFF);
    check("mid_err", err_count, 8'h00);
    check("mid_last", last_byte, 8'h00);
    check("mid_rd", rx_rd, 1'b0);
    check("mid_cmd", cmd_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push(8'h35);
    drain("post");
    check("post_err", err_count, 8'd1);
    check("post_status", cat_status, 8'hFF);
    check("post_cmds", cmd_cnt - c0, 0);

    check("rd_spacing", rd_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
